// File: rtl/rom_arbiter.sv
// Two-port round-robin arbiter in front of a single ROM: grant a port, give the ROM
// one sampling cycle, then capture its data/error and pulse that port's ack.
module rom_arbiter #(
  parameter int unsigned AW    = 4,
  parameter int unsigned EXTRA = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        a_req,
  input  logic                        b_req,
  input  logic [AW:0]                 a_addr,
  input  logic [AW:0]                 b_addr,
  input  logic [EXTRA-1:0]            a_extra,
  input  logic [EXTRA-1:0]            b_extra,
  input  logic [AW:0]                 a_lower,
  input  logic [AW:0]                 a_upper,
  input  logic [AW:0]                 b_lower,
  input  logic [AW:0]                 b_upper,
  output logic                        a_ack,
  output logic                        b_ack,
  output logic [(2**EXTRA)*8-1:0]     a_data,
  output logic [(2**EXTRA)*8-1:0]     b_data,
  output logic                        a_error,
  output logic                        b_error,
  output logic [AW:0]                 mem_addr,
  output logic [EXTRA-1:0]            mem_extra,
  output logic [AW:0]                 mem_lower_bound,
  output logic [AW:0]                 mem_upper_bound,
  input  logic [(2**EXTRA)*8-1:0]     mem_data,
  input  logic                        mem_error,
  output logic                        busy,
  output logic                        owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   cand_a;
  logic   cand_b;
  logic   grant;
  logic   grant_b;
  logic   capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grants happen from IDLE or straight out of RESP; in RESP the owner is masked
  // so a req still held during its own completion does not earn a second access.
  always_comb begin
    state_next = state;
    cand_a     = 1'b0;
    cand_b     = 1'b0;
    capture    = 1'b0;
    grant      = 1'b0;
    grant_b    = 1'b0;
    case (state)
      IDLE: begin
        cand_a = a_req;
        cand_b = b_req;
      end
      READ: begin
        state_next = RESP;
      end
      RESP: begin
        capture    = 1'b1;
        cand_a     = a_req & owner;
        cand_b     = b_req & ~owner;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    grant   = cand_a | cand_b;
    grant_b = cand_b & (~cand_a | ~owner);
    if (grant) begin
      state_next = READ;
    end
  end

  // Request path: latch the granted port's fields onto the ROM, hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner           <= 1'b1;
      busy            <= 1'b0;
      mem_addr        <= '0;
      mem_extra       <= '0;
      mem_lower_bound <= '0;
      mem_upper_bound <= '0;
    end else begin
      busy <= (state_next != IDLE);
      if (grant) begin
        owner           <= grant_b;
        mem_addr        <= grant_b ? b_addr  : a_addr;
        mem_extra       <= grant_b ? b_extra : a_extra;
        mem_lower_bound <= grant_b ? b_lower : a_lower;
        mem_upper_bound <= grant_b ? b_upper : a_upper;
      end
    end
  end

  // Response path: only the owner's ack/data/error change on a capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      a_data  <= '0;
      b_data  <= '0;
      a_error <= 1'b0;
      b_error <= 1'b0;
    end else begin
      a_ack <= capture & ~owner;
      b_ack <= capture & owner;
      if (capture && !owner) begin
        a_data  <= mem_data;
        a_error <= mem_error;
      end
      if (capture && owner) begin
        b_data  <= mem_data;
        b_error <= mem_error;
      end
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: a behavioural ROM, per-port transaction scoreboard with
// latency/fairness bounds, directed corner cases and a randomized two-port phase.
module tb_rom_arbiter;
  localparam int unsigned AW    = 4;
  localparam int unsigned EXTRA = 4;
  localparam int unsigned DW    = (2**EXTRA) * 8;
  localparam int unsigned AB    = AW + 1;
  localparam int unsigned ROM_N = 2**AB;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic             a_req = 1'b0;
  logic             b_req = 1'b0;
  logic [AW:0]      a_addr = '0, b_addr = '0;
  logic [EXTRA-1:0] a_extra = '0, b_extra = '0;
  logic [AW:0]      a_lower = '0, a_upper = '0, b_lower = '0, b_upper = '0;
  logic             a_ack, b_ack, a_error, b_error, busy, owner;
  logic [DW-1:0]    a_data, b_data;
  logic [AW:0]      mem_addr, mem_lower_bound, mem_upper_bound;
  logic [EXTRA-1:0] mem_extra;
  logic [DW-1:0]    mem_data  = '0;
  logic             mem_error = 1'b0;

  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  bit            mon_en = 1'b0;
  logic [7:0]    rom [ROM_N];
  logic [DW-1:0] hold_d [2];
  logic          hold_e [2];
  int            ack_port [$];
  int            ack_cyc  [$];

  rom_arbiter #(.AW(AW), .EXTRA(EXTRA)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .b_req(b_req),
    .a_addr(a_addr), .b_addr(b_addr),
    .a_extra(a_extra), .b_extra(b_extra),
    .a_lower(a_lower), .a_upper(a_upper),
    .b_lower(b_lower), .b_upper(b_upper),
    .a_ack(a_ack), .b_ack(b_ack),
    .a_data(a_data), .b_data(b_data),
    .a_error(a_error), .b_error(b_error),
    .mem_addr(mem_addr), .mem_extra(mem_extra),
    .mem_lower_bound(mem_lower_bound), .mem_upper_bound(mem_upper_bound),
    .mem_data(mem_data), .mem_error(mem_error),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM contents: bytes addr..addr+extra packed little-endian, upper bytes zero.
  function automatic logic [DW-1:0] rom_read(input int addr, input int extra);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < 2**EXTRA; i++) begin
      if (i <= extra) d[i*8 +: 8] = rom[(addr + i) % ROM_N];
    end
    return d;
  endfunction

  function automatic logic rom_err(input int addr, input int extra, input int lower, input int upper);
    return (addr < lower) || (addr + extra > upper);
  endfunction

  // ROM device: samples its request at a rising edge, answers one cycle later.
  always @(posedge clk) begin
    mem_data  <= rom_read(int'(mem_addr), int'(mem_extra));
    mem_error <= rom_err(int'(mem_addr), int'(mem_extra), int'(mem_lower_bound), int'(mem_upper_bound));
  end

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("ack_exclusive", DW'(a_ack & b_ack), DW'(0));
      if (a_ack) begin ack_port.push_back(0); ack_cyc.push_back(cyc); end
      if (b_ack) begin ack_port.push_back(1); ack_cyc.push_back(cyc); end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic drive(input bit port, input logic req, input int addr, input int extra,
                       input int lower, input int upper);
    if (port) begin
      b_req = req; b_addr = AB'(addr); b_extra = EXTRA'(extra);
      b_lower = AB'(lower); b_upper = AB'(upper);
    end else begin
      a_req = req; a_addr = AB'(addr); a_extra = EXTRA'(extra);
      a_lower = AB'(lower); a_upper = AB'(upper);
    end
  endtask

  task automatic clear_log();
    ack_port.delete();
    ack_cyc.delete();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    drive(1'b1, 1'b0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int p = 0; p < 2; p++) begin hold_d[p] = '0; hold_e[p] = 1'b0; end
  endtask

  // One request on a port, held until its ack; checks data, error and latency.
  task automatic port_access(input bit port, input int addr, input int extra, input int lower,
                             input int upper, input int max_lat, output int lat);
    logic [DW-1:0] exp_d;
    logic          exp_e;
    logic          seen;
    string         nm;
    nm    = port ? "b" : "a";
    exp_d = rom_read(addr, extra);
    exp_e = rom_err(addr, extra, lower, upper);
    drive(port, 1'b1, addr, extra, lower, upper);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 12) begin
      @(negedge clk);
      lat++;
      seen = port ? b_ack : a_ack;
      if (!seen) check_eq({nm, "_data_hold"}, port ? b_data : a_data, hold_d[port]);
    end
    check_eq({nm, "_ack_seen"}, DW'(seen), DW'(1));
    check_eq({nm, "_latency_ok"}, DW'(lat <= max_lat), DW'(1));
    if (seen) begin
      check_eq({nm, "_data"}, port ? b_data : a_data, exp_d);
      check_eq({nm, "_error"}, DW'(port ? b_error : a_error), DW'(exp_e));
      hold_d[port] = exp_d;
      hold_e[port] = exp_e;
    end
    drive(port, 1'b0, addr, extra, lower, upper);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_a_ack"}, DW'(a_ack), DW'(0));
    check_eq({tag, "_b_ack"}, DW'(b_ack), DW'(0));
    check_eq({tag, "_a_data"}, a_data, DW'(0));
    check_eq({tag, "_b_data"}, b_data, DW'(0));
    check_eq({tag, "_errors"}, DW'({a_error, b_error}), DW'(0));
    check_eq({tag, "_mem"}, DW'({mem_addr, mem_extra, mem_lower_bound, mem_upper_bound}), DW'(0));
    check_eq({tag, "_busy"}, DW'(busy), DW'(0));
    check_eq({tag, "_owner"}, DW'(owner), DW'(1));
  endtask

  initial begin
    int lat_a;
    int lat_b;
    for (int i = 0; i < ROM_N; i++) rom[i] = 8'($urandom_range(1, 255));
    apply_reset();
    check_reset_state("reset");
    mon_en = 1'b1;

    // Single A fetch from idle
    drive(1'b0, 1'b1, 0, 3, 0, 31);
    @(negedge clk);
    check_eq("fetch_mem_addr", DW'(mem_addr), DW'(0));
    check_eq("fetch_mem_extra", DW'(mem_extra), DW'(3));
    check_eq("fetch_busy", DW'(busy), DW'(1));
    check_eq("fetch_owner", DW'(owner), DW'(0));
    @(negedge clk);
    check_eq("fetch_ack_early", DW'(a_ack), DW'(0));
    @(negedge clk);
    check_eq("fetch_ack", DW'(a_ack), DW'(1));
    check_eq("fetch_data", a_data, rom_read(0, 3));
    check_eq("fetch_error", DW'(a_error), DW'(0));
    drive(1'b0, 1'b0, 0, 3, 0, 31);
    hold_d[0] = rom_read(0, 3);
    @(negedge clk);
    check_eq("fetch_ack_once", DW'(a_ack), DW'(0));
    check_eq("fetch_idle", DW'(busy), DW'(0));

    // Contention straight after reset: A first, B two cycles later
    apply_reset();
    check_reset_state("reset2");
    clear_log();
    fork
      port_access(1'b0, 5, 1, 0, 31, 3, lat_a);
      port_access(1'b1, 9, 2, 0, 31, 5, lat_b);
    join
    @(negedge clk);
    check_eq("cont_lat_a", DW'(lat_a), DW'(3));
    check_eq("cont_n_acks", DW'(ack_port.size()), DW'(2));
    if (ack_port.size() == 2) begin
      check_eq("cont_order", DW'({ack_port[0][0], ack_port[1][0]}), DW'(2'b01));
      check_eq("cont_spacing", DW'(ack_cyc[1] - ack_cyc[0]), DW'(2));
    end

    // Round-robin with both ports requesting continuously for six accesses
    clear_log();
    fork
      begin
        for (int k = 0; k < 3; k++)
          port_access(1'b0, int'($urandom_range(0, 31)), int'($urandom_range(0, 15)), 0, 31, 5, lat_a);
      end
      begin
        for (int k = 0; k < 3; k++)
          port_access(1'b1, int'($urandom_range(0, 31)), int'($urandom_range(0, 15)), 0, 31, 5, lat_b);
      end
      begin
        for (int j = 1; j <= 12; j++) begin
          @(negedge clk);
          check_eq("rr_busy", DW'(busy), DW'(1));
          if (j % 2 == 1) check_eq("rr_owner", DW'(owner), DW'(((j - 1) / 2) % 2));
        end
      end
    join
    @(negedge clk);
    check_eq("rr_n_acks", DW'(ack_port.size()), DW'(6));
    for (int i = 0; i < ack_port.size() && i < 6; i++) begin
      check_eq("rr_ack_port", DW'(ack_port[i]), DW'(i % 2));
      if (i > 0) check_eq("rr_ack_spacing", DW'(ack_cyc[i] - ack_cyc[i-1]), DW'(2));
    end

    // Out-of-window B access completes with an error; A's results untouched
    port_access(1'b1, 2, 1, 8, 15, 3, lat_b);
    check_eq("bnd_a_data", a_data, hold_d[0]);
    check_eq("bnd_a_error", DW'(a_error), DW'(hold_e[0]));
    check_eq("bnd_b_error", DW'(b_error), DW'(1));
    repeat (2) @(negedge clk);
    check_eq("idle_mem_hold", DW'({mem_addr, mem_lower_bound, mem_upper_bound}),
             DW'({AB'(2), AB'(8), AB'(15)}));
    check_eq("idle_busy", DW'(busy), DW'(0));

    // Reset during READ aborts the access
    clear_log();
    drive(1'b0, 1'b1, 7, 2, 0, 31);
    @(negedge clk);
    check_eq("rstread_busy", DW'(busy), DW'(1));
    reset = 1'b1;
    drive(1'b0, 1'b0, 7, 2, 0, 31);
    #1;
    check_reset_state("rstread");
    @(negedge clk);
    reset = 1'b0;
    for (int p = 0; p < 2; p++) begin hold_d[p] = '0; hold_e[p] = 1'b0; end
    repeat (4) @(negedge clk);
    check_eq("rstread_no_ack", DW'(ack_port.size()), DW'(0));
    fork
      port_access(1'b0, 12, 3, 0, 31, 3, lat_a);
      port_access(1'b1, 3, 0, 0, 31, 5, lat_b);
    join
    check_eq("rstread_lat_a", DW'(lat_a), DW'(3));
    @(negedge clk);

    // Request withdrawn during READ still completes exactly once
    clear_log();
    drive(1'b0, 1'b1, 20, 0, 16, 31);
    @(negedge clk);
    drive(1'b0, 1'b0, 20, 0, 16, 31);
    @(negedge clk);
    check_eq("wd_ack_early", DW'(a_ack), DW'(0));
    @(negedge clk);
    check_eq("wd_ack", DW'(a_ack), DW'(1));
    check_eq("wd_data", a_data, rom_read(20, 0));
    check_eq("wd_error", DW'(a_error), DW'(0));
    hold_d[0] = rom_read(20, 0);
    hold_e[0] = 1'b0;
    @(negedge clk);
    check_eq("wd_idle", DW'(busy), DW'(0));
    repeat (3) @(negedge clk);
    check_eq("wd_one_ack", DW'(ack_port.size()), DW'(1));

    // Randomized traffic on both ports
    clear_log();
    fork
      for (int k = 0; k < 20; k++) begin
        int lo;
        lo = int'($urandom_range(0, 31));
        repeat ($urandom_range(0, 3)) @(negedge clk);
        port_access(1'b0, int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
                    lo, int'($urandom_range(lo, 31)), 5, lat_a);
      end
      for (int k = 0; k < 20; k++) begin
        int lo;
        lo = int'($urandom_range(0, 31));
        repeat ($urandom_range(0, 3)) @(negedge clk);
        port_access(1'b1, int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
                    lo, int'($urandom_range(lo, 31)), 5, lat_b);
      end
    join
    @(negedge clk);
    check_eq("rand_n_acks", DW'(ack_port.size()), DW'(40));

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
